// File: rtl/fp_vec3_normalize_folded.sv
// Folded 3-vector normalizer: squares and scales through one shared fixed-point multiplier
// and borrows an external inverse-square-root unit. fp is signed Q32.32; vec3 packs x[63:0], y[127:64], z[191:128].
module fp_vec3_normalize_folded #(
    parameter logic signed [63:0] ZERO_EPS = 64'sd0
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [191:0] a_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [191:0] res_out,
    output logic         valid_out,
    output logic [63:0]  isqrt_a_out,
    output logic         isqrt_valid_out,
    input  logic         isqrt_ready_in,
    input  logic [63:0]  isqrt_res_in,
    input  logic         isqrt_valid_in
);

    typedef enum logic [3:0] {
        IDLE, SQ_X, SQ_Y, SQ_Z, ISSUE, WAIT, SC_X, SC_Y, SC_Z
    } state_t;

    state_t state, state_next;

    logic signed [63:0] vx, vy, vz;
    logic signed [63:0] acc, scale;
    logic signed [63:0] mul_a, mul_b, mul_p, acc_sum;
    logic               first_wait;

    // Products keep Q32.32 by dropping the low 32 fraction bits; high bits wrap.
    function automatic logic signed [63:0] fp_mul(input logic signed [63:0] a, input logic signed [63:0] b);
        logic signed [127:0] wa, wb;
        wa = a;
        wb = b;
        return 64'((wa * wb) >>> 32);
    endfunction

    function automatic logic signed [63:0] fp_add(input logic signed [63:0] a, input logic signed [63:0] b);
        return a + b;
    endfunction

    always_comb begin
        mul_a = vx;
        mul_b = vx;
        case (state)
            SQ_Y:    begin mul_a = vy; mul_b = vy;    end
            SQ_Z:    begin mul_a = vz; mul_b = vz;    end
            SC_X:    begin mul_a = vx; mul_b = scale; end
            SC_Y:    begin mul_a = vy; mul_b = scale; end
            SC_Z:    begin mul_a = vz; mul_b = scale; end
            default: begin mul_a = vx; mul_b = vx;    end
        endcase
        mul_p   = fp_mul(mul_a, mul_b);
        acc_sum = fp_add(acc, mul_p);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_in) state_next = SQ_X;
            SQ_X:    state_next = SQ_Y;
            SQ_Y:    state_next = SQ_Z;
            SQ_Z:    state_next = (acc_sum <= ZERO_EPS) ? IDLE : ISSUE;
            ISSUE:   if (isqrt_ready_in) state_next = WAIT;
            // The first WAIT cycle may still see the unit's previous result.
            WAIT:    if (!first_wait && isqrt_valid_in) state_next = SC_X;
            SC_X:    state_next = SC_Y;
            SC_Y:    state_next = SC_Z;
            SC_Z:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ready_out       = (state == IDLE);
    assign isqrt_valid_out = (state == ISSUE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vx          <= '0;
            vy          <= '0;
            vz          <= '0;
            acc         <= '0;
            scale       <= '0;
            first_wait  <= 1'b0;
            res_out     <= '0;
            valid_out   <= 1'b0;
            isqrt_a_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        vx        <= a_in[63:0];
                        vy        <= a_in[127:64];
                        vz        <= a_in[191:128];
                        acc       <= '0;
                        valid_out <= 1'b0;
                    end
                end
                SQ_X, SQ_Y: acc <= acc_sum;
                SQ_Z: begin
                    acc <= acc_sum;
                    if (acc_sum <= ZERO_EPS) begin
                        res_out   <= '0;
                        valid_out <= 1'b1;
                    end else begin
                        isqrt_a_out <= acc_sum;
                    end
                end
                ISSUE: if (isqrt_ready_in) first_wait <= 1'b1;
                WAIT: begin
                    first_wait <= 1'b0;
                    if (!first_wait && isqrt_valid_in) scale <= isqrt_res_in;
                end
                SC_X: res_out[63:0]    <= mul_p;
                SC_Y: res_out[127:64]  <= mul_p;
                SC_Z: begin
                    res_out[191:128] <= mul_p;
                    valid_out        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
